// File: rtl/shiftn_burst_if.sv
// Handshake and data bundle for shiftn_burst: load/burst controls in,
// register contents and burst status out.
interface shiftn_burst_if #(
  parameter int N  = 8,
  parameter int CW = 4
);
  logic [N-1:0]  R;
  logic          Load;
  logic          Start;
  logic [CW-1:0] Len;
  logic          Dir;
  logic          Rot;
  logic          w;
  logic [N-1:0]  Q;
  logic          SerOut;
  logic          Busy;
  logic          Done;

  modport master (
    output R, Load, Start, Len, Dir, Rot, w,
    input  Q, SerOut, Busy, Done
  );

  modport slave (
    input  R, Load, Start, Len, Dir, Rot, w,
    output Q, SerOut, Busy, Done
  );
endinterface

// File: rtl/shiftn_burst.sv
// N-bit shift register with parallel load and a counted burst engine that
// shifts/rotates Len times after a single Start, then pulses Done.
//
// state | meaning
// IDLE  | accepts Load (priority) or Start; register holds otherwise
// SHIFT | one shift per edge with latched Dir/Rot until counter reaches 0
module shiftn_burst #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic           Clock,
  input  logic           Resetn,
  shiftn_burst_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ser_q, ser_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dir_q, dir_d;
  logic          rot_q, rot_d;
  logic          fill;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    rot_d   = rot_q;
    fill    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Load) begin
          q_d = bus.R;
        end else if (bus.Start) begin
          if (bus.Len != '0) begin
            dir_d   = bus.Dir;
            rot_d   = bus.Rot;
            cnt_d   = bus.Len;
            state_d = SHIFT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        // Shift direction/rotate come from the values latched at Start.
        if (dir_q) begin
          fill  = rot_q ? q_q[N-1] : bus.w;
          q_d   = {q_q[N-2:0], fill};
          ser_d = q_q[N-1];
        end else begin
          fill  = rot_q ? q_q[0] : bus.w;
          q_d   = {fill, q_q[N-1:1]};
          ser_d = q_q[0];
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  assign bus.Q      = q_q;
  assign bus.SerOut = ser_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;

endmodule

// File: tb/tb_shiftn_burst.sv
// Self-checking bench for shiftn_burst: directed vector table, hand-written
// corner sequences and randomized bursts against a behavioural model.
module tb_shiftn_burst;
  localparam int N  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [N-1:0] m_q;
  logic         m_ser;

  shiftn_burst_if #(.N(N), .CW(CW)) bus ();

  shiftn_burst #(.N(N), .CW(CW)) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          load;
    logic          start;
    logic [N-1:0]  r;
    logic [CW-1:0] len;
    logic          dir;
    logic          rot;
    logic          w;
    logic [N-1:0]  exp_q;
    logic          exp_ser;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Load = 1'b0; bus.Start = 1'b0; bus.R = '0; bus.Len = '0;
    bus.Dir = 1'b0; bus.Rot = 1'b0; bus.w = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] q, input logic ser,
                           input logic busy, input logic done);
    check({tag, ".Q"}, 32'(bus.Q), 32'(q));
    check({tag, ".SerOut"}, 32'(bus.SerOut), 32'(ser));
    check({tag, ".Busy"}, 32'(bus.Busy), 32'(busy));
    check({tag, ".Done"}, 32'(bus.Done), 32'(done));
  endtask

  // Reference: one shift computed arithmetically on the model value.
  task automatic model_shift(input logic dir, input logic rot, input logic win);
    logic f;
    if (dir) begin
      f     = rot ? m_q[N-1] : win;
      m_ser = m_q[N-1];
      m_q   = (m_q << 1) | N'(f);
    end else begin
      f     = rot ? m_q[0] : win;
      m_ser = m_q[0];
      m_q   = (m_q >> 1) | (N'(f) << (N - 1));
    end
  endtask

  task automatic do_load(input logic [N-1:0] r);
    idle_inputs();
    bus.Load = 1'b1; bus.R = r;
    bus.Start = 1'($urandom_range(0, 1));
    bus.Len = CW'($urandom_range(0, 15));
    step();
    m_q = r;
    check_all("load", m_q, m_ser, 1'b0, 1'b0);
    idle_inputs();
  endtask

  // Issue Start and follow the whole burst cycle by cycle. With noise set,
  // Load/Start/Len/Dir/Rot/R wiggle during SHIFT and must have no effect.
  task automatic run_burst(input int len, input logic dir, input logic rot, input bit noise);
    idle_inputs();
    bus.Start = 1'b1; bus.Len = CW'(len); bus.Dir = dir; bus.Rot = rot;
    step();
    if (len == 0) begin
      check_all("start0", m_q, m_ser, 1'b0, 1'b1);
      idle_inputs();
      return;
    end
    check_all("start", m_q, m_ser, 1'b1, 1'b0);
    for (int i = 1; i <= len; i++) begin
      idle_inputs();
      bus.w = 1'($urandom_range(0, 1));
      if (noise) begin
        bus.Load = 1'($urandom_range(0, 1)); bus.Start = 1'($urandom_range(0, 1));
        bus.R = N'($urandom); bus.Len = CW'($urandom);
        bus.Dir = ~dir; bus.Rot = 1'($urandom_range(0, 1));
      end
      model_shift(dir, rot, bus.w);
      step();
      check_all("shift", m_q, m_ser, (i < len), (i == len));
    end
    idle_inputs();
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1,0,8'hA5,0,0,0,0, 8'hA5,0,0,0};
    tbl[1]  = '{1,0,8'h81,0,0,0,0, 8'h81,0,0,0};
    tbl[2]  = '{0,1,8'h00,3,0,0,1, 8'h81,0,1,0};
    tbl[3]  = '{0,0,8'h00,0,0,0,1, 8'hC0,1,1,0};
    tbl[4]  = '{0,0,8'h00,0,0,0,1, 8'hE0,0,1,0};
    tbl[5]  = '{0,0,8'h00,0,0,0,1, 8'hF0,0,0,1};
    tbl[6]  = '{0,0,8'h00,0,0,0,0, 8'hF0,0,0,0};
    tbl[7]  = '{1,0,8'h3C,0,0,0,0, 8'h3C,0,0,0};
    tbl[8]  = '{0,1,8'h00,4,1,1,0, 8'h3C,0,1,0};
    tbl[9]  = '{0,0,8'h00,0,0,0,1, 8'h78,0,1,0};
    tbl[10] = '{0,0,8'h00,0,0,0,1, 8'hF0,0,1,0};
    tbl[11] = '{0,0,8'h00,0,0,0,0, 8'hE1,1,1,0};
    tbl[12] = '{0,0,8'h00,0,0,0,0, 8'hC3,1,0,1};
    tbl[13] = '{0,1,8'h00,0,1,0,0, 8'hC3,1,0,1};
    tbl[14] = '{0,0,8'h00,0,0,0,0, 8'hC3,1,0,0};
    tbl[15] = '{1,1,8'h5A,3,0,0,0, 8'h5A,1,0,0};

    idle_inputs();
    #3;
    check_all("reset", '0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bus.Load = tbl[i].load; bus.Start = tbl[i].start; bus.R = tbl[i].r;
      bus.Len = tbl[i].len; bus.Dir = tbl[i].dir; bus.Rot = tbl[i].rot; bus.w = tbl[i].w;
      step();
      check_all($sformatf("vec%0d", i), tbl[i].exp_q, tbl[i].exp_ser,
                tbl[i].exp_busy, tbl[i].exp_done);
    end
    idle_inputs();
    m_q = 8'h5A; m_ser = 1'b1;

    // Rotate by N returns the original value.
    do_load(8'h3C);
    run_burst(8, 1'b1, 1'b1, 1'b0);
    check("rot8", 32'(bus.Q), 32'h3C);

    // Len=0, then a noisy Len=5 burst, then Start in the Done cycle.
    run_burst(0, 1'b0, 1'b0, 1'b0);
    step();
    check_all("after_len0", m_q, m_ser, 1'b0, 1'b0);
    run_burst(5, 1'b0, 1'b1, 1'b1);
    run_burst(2, 1'b1, 1'b0, 1'b0);
    do_load(8'h96);

    // Asynchronous reset between edges in the middle of a burst.
    bus.Start = 1'b1; bus.Len = CW'(5);
    step();
    idle_inputs();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", '0, 1'b0, 1'b0, 1'b0);
    step();
    check_all("rst_hold", '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check_all("rst_release", '0, 1'b0, 1'b0, 1'b0);
    m_q = '0; m_ser = 1'b0;
    run_burst(2, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) do_load(N'($urandom));
      else run_burst(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        step();
        check_all("gap", m_q, m_ser, 1'b0, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shiftn_burst.md
Name: shiftn_burst

Overview:
- Parametrised N-bit shift register with parallel load, left/right shift, rotate or serial-fill, and a counted burst engine.
- A single Start command shifts the register a programmed number of times and then reports completion.
- Used as a serialiser/deserialiser and bit-aligner next to the existing per-bit mux+DFF shift chains.
- Right shift keeps the established convention: serial input w enters the MSB and bits leave via bit 0.

Parameters:
- N, 8, register width in bits; must be >= 2.
- CW, 4, width of the Len shift-count input and the internal counter; must satisfy CW >= clog2(N+1).

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous active-low reset.
- R  input  N  parallel load data.
- Load  input  1  parallel load request; honoured in IDLE only.
- Start  input  1  burst start request; honoured in IDLE only.
- Len  input  CW  number of shifts in the burst (0..2^CW-1).
- Dir  input  1  0 = shift right (toward bit 0), 1 = shift left.
- Rot  input  1  1 = rotate, 0 = fill from w.
- w  input  1  serial input, sampled live on every shift edge.
- Q  output  N  register contents.
- SerOut  output  1  registered copy of the last bit shifted out.
- Busy  output  1  high while a burst is in progress.
- Done  output  1  one-cycle pulse marking burst completion.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - Resetn low forces Q=0, SerOut=0, Busy=0, Done=0, counter=0 and state IDLE immediately, with no clock edge required.
  - This includes reset asserted mid-burst; the aborted burst produces no Done.
- States: IDLE, SHIFT. Busy is registered and equals (state==SHIFT).
- IDLE priority at each rising edge:
  1. Load=1: Q<=R. Start is ignored. State stays IDLE.
  2. Else Start=1 and Len!=0: latch Dir, Rot and Len (Len into the counter); state<=SHIFT. Q does not change on this edge.
  3. Else Start=1 and Len=0: Done<=1 for one cycle. No shift. State stays IDLE.
  4. Else: hold.
- SHIFT, each rising edge:
  - Perform exactly one shift using the latched Dir/Rot and decrement the counter.
  - If the counter was 1: state<=IDLE, Busy<=0, Done<=1.
  - Load, Start, Len, Dir and Rot are ignored throughout SHIFT.
- Shift right:
  - Q <= {f, Q[N-1:1]}, where f = Rot ? Q[0] : w.
  - SerOut <= Q[0].
- Shift left:
  - Q <= {Q[N-2:0], f}, where f = Rot ? Q[N-1] : w.
  - SerOut <= Q[N-1].
- SerOut changes only on shift edges; it holds otherwise, including across Load.
- Latency and Done timing:
  - Start accepted at edge k gives shifts at edges k+1 .. k+Len.
  - Busy is high for exactly Len cycles.
  - Done is high during the cycle after edge k+Len, coincident with Busy low.
- Back-to-back bursts:
  - Done clears after one cycle unless the next edge sets it again.
  - A Start or Load in the Done cycle is accepted, since the state is IDLE.
- Len greater than N is legal; shifting continues. Rotating by N returns the original value.
- No arithmetic beyond the CW-bit down-counter; the counter never wraps because it stops at 1→0.

Test Plan:
1. N=8. Reset, then Load R=0xA5 → Q=0xA5 after one edge; Busy=0, Done=0, SerOut=0.
2. Load 0x81, then Start Len=3, Dir=0, Rot=0, w=1 → Q sequence 0xC0, 0xE0, 0xF0; SerOut sequence 1, 0, 0; Busy high exactly 3 cycles; one Done pulse as Busy falls.
3. Load 0x3C, then Start Len=4, Dir=1, Rot=1 → Q=0xC3. Repeat with Len=8 → Q=0x3C; Done pulse after 8 shift cycles.
4. Start Len=0 → Done pulses once next cycle; Q unchanged; Busy never rises. During a Len=5 burst, pulse Load R=0xFF and Start with Dir toggled → both ignored; burst completes unchanged.
5. Drop Resetn mid-burst between clock edges → Q=0, Busy=0, SerOut=0 immediately; no Done. After release, Start Len=2 runs normally.
6. Load=1 and Start=1 in the same IDLE cycle → Q<=R, Busy stays 0. Start asserted in the Done cycle → new burst begins; Busy rises next cycle.
